// File: rtl/disp_scheduler.sv
// Time-shares the 4-digit BCD display between NUM_SRC binary sources with dwell rotation and strobe pre-emption.
// Latency: bcd_out commits 16 cycles after LOAD (1 load + 14 shift-add-3 + 1 commit); triggers while busy merge into one pending slot.
module disp_scheduler #(
    parameter int NUM_SRC = 4,
    parameter int DWELL   = 100000000,
    parameter int CNT_W   = 27
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [14*NUM_SRC-1:0]   i_value_in,
    input  logic [NUM_SRC-1:0]      i_upd,
    input  logic                    i_hold,
    output logic [15:0]             o_bcd_out,
    output logic [1:0]              o_src_sel,
    output logic                    o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CONVERT,
        S_COMMIT
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [1:0]       LP_SRC_LAST = 2'(NUM_SRC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pending;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_src_sel;
    logic [13:0]       r_bin;
    logic [15:0]       r_acc;
    logic [3:0]        r_iter;
    logic [15:0]       r_bcd;
    logic              r_busy;

    logic              w_any_upd;
    logic [1:0]        w_upd_idx;
    logic              w_wrap;
    logic [13:0]       w_raw;
    logic [13:0]       w_cap;
    logic [15:0]       w_acc_adj;
    logic              w_take_pending;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        w_any_upd = |i_upd;
        w_upd_idx = 2'd0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (i_upd[k]) w_upd_idx = 2'(k);
        end
        w_wrap = !i_hold && (r_cnt == LP_CNT_LAST);
    end

    always_comb begin
        w_raw = 14'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (r_src_sel == 2'(k)) w_raw = i_value_in[14*k +: 14];
        end
        w_cap = (w_raw > 14'd9999) ? 14'd9999 : w_raw;
    end

    assign w_acc_adj = {add3(r_acc[15:12]), add3(r_acc[11:8]),
                        add3(r_acc[7:4]),   add3(r_acc[3:0])};

    always_comb begin
        w_state_nxt    = r_state;
        w_take_pending = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending) begin
                    w_take_pending = 1'b1;
                    w_state_nxt    = S_LOAD;
                end
            end
            S_LOAD:    w_state_nxt = S_CONVERT;
            S_CONVERT: if (r_iter == 4'd13) w_state_nxt = S_COMMIT;
            S_COMMIT:  w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Override beats a coincident dwell wrap; hold never blocks an override.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_src_sel <= 2'd0;
            r_pending <= 1'b1;
        end else begin
            if (w_any_upd) begin
                r_cnt     <= '0;
                r_src_sel <= w_upd_idx;
            end else if (!i_hold) begin
                if (w_wrap) begin
                    r_cnt     <= '0;
                    r_src_sel <= (r_src_sel == LP_SRC_LAST) ? 2'd0 : r_src_sel + 2'd1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_any_upd || w_wrap) r_pending <= 1'b1;
            else if (w_take_pending) r_pending <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin  <= 14'd0;
            r_acc  <= 16'd0;
            r_iter <= 4'd0;
            r_bcd  <= 16'd0;
            r_busy <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_bin  <= w_cap;
                    r_acc  <= 16'd0;
                    r_iter <= 4'd0;
                    r_busy <= 1'b1;
                end
                S_CONVERT: begin
                    r_acc  <= {w_acc_adj[14:0], r_bin[13]};
                    r_bin  <= {r_bin[12:0], 1'b0};
                    r_iter <= r_iter + 4'd1;
                end
                S_COMMIT: begin
                    r_bcd  <= r_acc;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_bcd_out = r_bcd;
    assign o_src_sel = r_src_sel;
    assign o_busy    = r_busy;

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with DWELL=40; edge numbers below count rising edges from time zero.
module tb_disp_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] value_in;
    logic [3:0]  upd;
    logic        hold;
    logic [15:0] bcd_out;
    logic [1:0]  src_sel;
    logic        busy;

    int t      = 0;
    int n_vec  = 0;
    int n_err  = 0;

    always #5 clk = ~clk;

    disp_scheduler #(.NUM_SRC(4), .DWELL(40), .CNT_W(6)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_value_in (value_in),
        .i_upd      (upd),
        .i_hold     (hold),
        .o_bcd_out  (bcd_out),
        .o_src_sel  (src_sel),
        .o_busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s @edge %0d: observed %0h expected %0h", tag, t, obs, exp);
        end
    endtask

    // Advance to 1 time unit after rising edge e; outputs are stable there and inputs
    // written afterwards are sampled at edge e+1.
    task automatic goto(input int e);
        if (e < t) begin
            n_vec++;
            n_err++;
            $display("FAIL goto: observed edge %0d required edge >= %0d", e, t);
        end else if (e > t) begin
            repeat (e - t) @(posedge clk);
            t = e;
            #1;
        end
    endtask

    task automatic set_val(input int k, input logic [13:0] v);
        value_in[14*k +: 14] = v;
    endtask

    initial begin
        logic [1:0]  rot_src  [4];
        logic [15:0] rot_bcd  [4];
        logic [15:0] rot_prev [4];
        int          w;

        rot_src  = '{2'd1, 2'd2, 2'd3, 2'd0};
        rot_bcd  = '{16'h0058, 16'h0960, 16'h9999, 16'h0007};
        rot_prev = '{16'h1234, 16'h0058, 16'h0960, 16'h9999};

        rst      = 1'b1;
        upd      = 4'b0000;
        hold     = 1'b0;
        value_in = {14'd9999, 14'd960, 14'd58, 14'd1234};

        // Reset and first conversion of source 0
        goto(1);
        chk("rst_bcd", 32'(bcd_out), 32'h0000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_src", 32'(src_sel), 32'd0);
        goto(2);
        chk("rst2_bcd", 32'(bcd_out), 32'h0000);
        rst = 1'b0;
        goto(3);
        chk("load_busy_low", 32'(busy), 32'd0);
        goto(4);
        chk("busy_rise", 32'(busy), 32'd1);
        goto(18);
        chk("first_pre_bcd", 32'(bcd_out), 32'h0000);
        chk("first_pre_busy", 32'(busy), 32'd1);
        goto(19);
        chk("first_bcd", 32'(bcd_out), 32'h1234);
        chk("first_busy", 32'(busy), 32'd0);
        chk("first_src", 32'(src_sel), 32'd0);

        // Rotation: wraps at edges 42, 82, 122, 162; display lands 17 edges later
        for (int i = 0; i < 4; i++) begin
            w = 42 + 40 * i;
            if (i == 3) set_val(0, 14'd7);
            goto(w - 1);
            chk("rot_src_before", 32'(src_sel), 32'(rot_src[(i + 3) % 4]));
            goto(w);
            chk("rot_src_after", 32'(src_sel), 32'(rot_src[i]));
            goto(w + 2);
            chk("rot_busy", 32'(busy), 32'd1);
            goto(w + 16);
            chk("rot_bcd_hold", 32'(bcd_out), 32'(rot_prev[i]));
            goto(w + 17);
            chk("rot_bcd", 32'(bcd_out), 32'(rot_bcd[i]));
        end

        // Saturation and boundaries on source 1
        set_val(1, 14'd16383);
        goto(202);
        chk("sat_src", 32'(src_sel), 32'd1);
        goto(218);
        chk("sat_pre", 32'(bcd_out), 32'h0007);
        goto(219);
        chk("sat_16383", 32'(bcd_out), 32'h9999);
        hold = 1'b1;
        set_val(1, 14'd10000);
        goto(220);
        upd = 4'b0010;
        goto(221);
        upd = 4'b0000;
        chk("self_upd_src", 32'(src_sel), 32'd1);
        goto(223);
        chk("self_upd_busy", 32'(busy), 32'd1);
        goto(238);
        chk("sat_10000", 32'(bcd_out), 32'h9999);
        chk("sat_10000_busy", 32'(busy), 32'd0);
        set_val(1, 14'd0);
        goto(239);
        upd = 4'b0010;
        goto(240);
        upd = 4'b0000;
        goto(256);
        chk("zero_pre", 32'(bcd_out), 32'h9999);
        goto(257);
        chk("zero_bcd", 32'(bcd_out), 32'h0000);

        // Override mid-dwell while held: lowest set bit wins, counter restarts
        set_val(1, 14'd4321);
        goto(259);
        hold = 1'b0;
        goto(261);
        upd = 4'b1000;
        goto(262);
        upd = 4'b0000;
        chk("ovr3_src", 32'(src_sel), 32'd3);
        goto(270);
        hold = 1'b1;
        goto(279);
        chk("ovr3_bcd", 32'(bcd_out), 32'h9999);
        goto(289);
        upd = 4'b1010;
        goto(290);
        upd = 4'b0000;
        chk("ovr1010_src", 32'(src_sel), 32'd1);
        goto(306);
        chk("ovr1010_pre", 32'(bcd_out), 32'h9999);
        goto(307);
        chk("ovr1010_bcd", 32'(bcd_out), 32'h4321);
        goto(309);
        hold = 1'b0;
        goto(318);
        chk("cnt_cleared", 32'(src_sel), 32'd1);
        goto(348);
        chk("wrap_pre", 32'(src_sel), 32'd1);
        goto(349);
        chk("wrap_after_clear", 32'(src_sel), 32'd2);
        goto(366);
        chk("wrap_bcd", 32'(bcd_out), 32'h0960);

        // Wrap at edge 389 coincides with an override of source 0
        goto(388);
        chk("coinc_pre", 32'(src_sel), 32'd2);
        upd = 4'b0001;
        goto(389);
        upd = 4'b0000;
        chk("coinc_src", 32'(src_sel), 32'd0);
        goto(406);
        chk("coinc_bcd", 32'(bcd_out), 32'h0007);

        // Busy merge: two overrides during one conversion yield one follow-up of source 3
        hold = 1'b1;
        set_val(0, 14'd1111);
        goto(409);
        upd = 4'b0001;
        goto(410);
        upd = 4'b0000;
        goto(414);
        upd = 4'b0100;
        goto(415);
        upd = 4'b0000;
        chk("merge_busy", 32'(busy), 32'd1);
        goto(417);
        upd = 4'b1000;
        goto(418);
        upd = 4'b0000;
        chk("merge_src", 32'(src_sel), 32'd3);
        goto(426);
        chk("merge_pre", 32'(bcd_out), 32'h0007);
        goto(427);
        chk("merge_inflight", 32'(bcd_out), 32'h1111);
        chk("merge_inflight_busy", 32'(busy), 32'd0);
        goto(443);
        chk("merge_hold", 32'(bcd_out), 32'h1111);
        goto(444);
        chk("merge_follow", 32'(bcd_out), 32'h9999);
        goto(446);
        chk("merge_one_only", 32'(busy), 32'd0);

        // Reset in the 5th CONVERT cycle of a source-2 conversion
        goto(469);
        upd = 4'b0100;
        goto(470);
        upd = 4'b0000;
        chk("mid_src", 32'(src_sel), 32'd2);
        goto(476);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        goto(477);
        rst = 1'b0;
        chk("mid_rst_bcd", 32'(bcd_out), 32'h0000);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_src", 32'(src_sel), 32'd0);
        goto(478);
        chk("mid_reload_low", 32'(busy), 32'd0);
        goto(479);
        chk("mid_reload_busy", 32'(busy), 32'd1);
        goto(493);
        chk("mid_reload_pre", 32'(bcd_out), 32'h0000);
        goto(494);
        chk("mid_reload_bcd", 32'(bcd_out), 32'h1111);
        chk("mid_reload_src", 32'(src_sel), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
